seq_mult_3bit: RTL and testbench

Sequential shift-and-add unsigned multiplier, 3-bit x 3-bit -> 6-bit product. It is the control/register stage wrapped around the team's 3-bit ripple adder. It drives the adder's operands, consumes its sum and carry-out, and performs one add/shift iteration per clock. It exposes a start/busy/done handshake to the surrounding datapath.

---
 rtl/seq_mult_3bit_pkg.sv | 13 +
 rtl/seq_mult_3bit_adder.sv | 21 ++
 rtl/seq_mult_3bit.sv | 100 ++++++++++
 tb/tb_seq_mult_3bit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_3bit_pkg.sv
// Shared definitions for the 3x3 shift-and-add multiplier: FSM encoding and iteration count.
package seq_mult_3bit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NumIter = 3;
    localparam logic [1:0] LastCnt = 2'(NumIter - 1);

endpackage

// File: rtl/seq_mult_3bit_adder.sv
// 3-bit ripple-carry adder used as the multiplier's add stage.
module Adder_3_bit (
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       Cin,
    output logic [2:0] S,
    output logic       Cout
);

    logic [3:0] carry;

    always_comb begin
        carry[0] = Cin;
        for (int i = 0; i < 3; i++) begin
            S[i]         = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        Cout = carry[3];
    end

endmodule

// File: rtl/seq_mult_3bit.sv
// Sequential unsigned 3x3 multiplier: one add/shift iteration per clock around a ripple adder.
module seq_mult_3bit
    import seq_mult_3bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [5:0] P,
    output logic       busy,
    output logic       done
);

    state_e     state_q;
    logic [2:0] m_q, acc_q, q_q;
    logic       c_q;
    logic [1:0] cnt_q;
    logic [5:0] p_q;
    logic       busy_q, done_q;

    logic [2:0] sum;
    logic       cadd;
    logic [2:0] acc_d, q_d;
    logic       c_d;

    Adder_3_bit u_adder (
        .A    (acc_q),
        .B    (m_q),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cadd)
    );

    // Right shift of {C,ACC,Q}, taking the adder result when the multiplier LSB is set.
    always_comb begin
        c_d = 1'b0;
        if (q_q[0]) begin
            acc_d = {cadd, sum[2:1]};
            q_d   = {sum[0], q_q[2:1]};
        end else begin
            acc_d = {c_q, acc_q[2:1]};
            q_d   = {acc_q[0], q_q[2:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= A;
                        q_q     <= B;
                        acc_q   <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LastCnt) begin
                        p_q     <= {acc_d, q_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_mult_3bit.sv
// Directed self-checking bench for seq_mult_3bit.
module tb_seq_mult_3bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] a, b;
    logic [5:0] p;
    logic       busy, done;

    int checks;
    int errors;

    seq_mult_3bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .P     (p),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation from IDLE/DONE and check the full 4-cycle sequence; ends in the done cycle.
    task automatic run_op(input logic [2:0] av, input logic [2:0] bv, input logic [5:0] exp,
                          input string name);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s calc: busy=%b done=%b required busy=1 done=0", name, busy, done);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || p !== exp) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b P=%0d required done=1 busy=0 P=%0d",
                     name, done, busy, p, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if (p !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: P=%0d busy=%b done=%b required 0/0/0", p, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hold();
        run_op(3'd7, 3'd7, 6'd49, "7x7");
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || p !== 6'd49) begin
                errors++;
                $display("FAIL hold49: done=%b busy=%b P=%0d required 0/0/49", done, busy, p);
            end
        end
    endtask

    task automatic test_directed();
        run_op(3'd5, 3'd3, 6'd15, "5x3");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL 5x3 pulse: done=%b required 0", done);
        end
        run_op(3'd0, 3'd6, 6'd0, "0x6");
        @(posedge clk); #1;
        run_op(3'd6, 3'd0, 6'd0, "6x0");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || p !== 6'd0) begin
            errors++;
            $display("FAIL 6x0 after: done=%b P=%0d required 0/0", done, p);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 3'd3; b = 3'd2; start = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || p !== 6'd6) begin
            errors++;
            $display("FAIL b2b first: done=%b P=%0d required done=1 P=6", done, p);
        end
        @(negedge clk);
        a = 3'd4; b = 3'd5;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b reaccept: busy=%b done=%b required busy=1 done=0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || p !== 6'd20) begin
            errors++;
            $display("FAIL b2b second: done=%b P=%0d required done=1 P=20", done, p);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        pulses = 0;
        @(negedge clk);
        a = 3'd6; b = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        a = 3'd1; b = 3'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (p !== 6'd30) begin
                    errors++;
                    $display("FAIL ignore P: P=%0d required 30", p);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore pulses: done pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 3'd7; b = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (p !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async reset: P=%0d busy=%b done=%b required 0/0/0", p, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post reset idle: busy=%b done=%b required 0/0", busy, done);
        end
        run_op(3'd2, 3'd3, 6'd6, "2x3 after reset");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run_op(3'(i), 3'(j), 6'(i * j), "sweep");
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hold();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        test_sweep();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
